// File: rtl/dmi_jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller in front of the DMI JTAG transport.
// Serves IDCODE/BYPASS locally and strobes the downstream DTMCS/DMI registers.
module dmi_jtag_tap_ctrl #(
    parameter int unsigned IrLength    = 5,
    parameter logic [31:0] IdcodeValue = 32'h0000_0001
) (
    input  logic tck_i,
    input  logic trst_ni,
    input  logic tms_i,
    input  logic td_i,
    input  logic testmode_i,
    output logic td_o,
    output logic tdo_oe_o,
    output logic tck_o,
    output logic dmi_clear_o,
    output logic capture_o,
    output logic shift_o,
    output logic update_o,
    output logic tdi_o,
    output logic dtmcs_select_o,
    output logic dmi_select_o,
    input  logic dtmcs_tdo_i,
    input  logic dmi_tdo_i
);

    localparam int unsigned IR_W   = IrLength;
    localparam int unsigned IDC_W  = 32;

    localparam logic [IR_W-1:0] IR_IDCODE  = IR_W'(5'h01);
    localparam logic [IR_W-1:0] IR_DTMCS   = IR_W'(5'h10);
    localparam logic [IR_W-1:0] IR_DMI     = IR_W'(5'h11);
    localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(5'b00101);

    typedef enum logic [3:0] {
        TestLogicReset,
        RunTestIdle,
        SelectDrScan,
        CaptureDr,
        ShiftDr,
        Exit1Dr,
        PauseDr,
        Exit2Dr,
        UpdateDr,
        SelectIrScan,
        CaptureIr,
        ShiftIr,
        Exit1Ir,
        PauseIr,
        Exit2Ir,
        UpdateIr
    } tap_state_e;

    tap_state_e         r_state;
    tap_state_e         w_state_d;
    logic [IR_W-1:0]    r_ir_shift;
    logic [IR_W-1:0]    r_ir_q;
    logic [IDC_W-1:0]   r_idcode;
    logic               r_bypass;
    logic               r_td;
    logic               r_tdo_oe;
    logic               w_tdo;
    logic               w_sel_idcode;
    logic               w_sel_dtmcs;
    logic               w_sel_dmi;
    logic               w_sel_bypass;
    logic               w_unused;

    // DFT mode has no functional effect; the test clock passes straight through.
    assign w_unused = testmode_i;
    assign tck_o    = tck_i;
    assign tdi_o    = td_i;

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            r_state <= TestLogicReset;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            TestLogicReset: w_state_d = tms_i ? TestLogicReset : RunTestIdle;
            RunTestIdle:    w_state_d = tms_i ? SelectDrScan   : RunTestIdle;
            SelectDrScan:   w_state_d = tms_i ? SelectIrScan   : CaptureDr;
            CaptureDr:      w_state_d = tms_i ? Exit1Dr        : ShiftDr;
            ShiftDr:        w_state_d = tms_i ? Exit1Dr        : ShiftDr;
            Exit1Dr:        w_state_d = tms_i ? UpdateDr       : PauseDr;
            PauseDr:        w_state_d = tms_i ? Exit2Dr        : PauseDr;
            Exit2Dr:        w_state_d = tms_i ? UpdateDr       : ShiftDr;
            UpdateDr:       w_state_d = tms_i ? SelectDrScan   : RunTestIdle;
            SelectIrScan:   w_state_d = tms_i ? TestLogicReset : CaptureIr;
            CaptureIr:      w_state_d = tms_i ? Exit1Ir        : ShiftIr;
            ShiftIr:        w_state_d = tms_i ? Exit1Ir        : ShiftIr;
            Exit1Ir:        w_state_d = tms_i ? UpdateIr       : PauseIr;
            PauseIr:        w_state_d = tms_i ? Exit2Ir        : PauseIr;
            Exit2Ir:        w_state_d = tms_i ? UpdateIr       : ShiftIr;
            UpdateIr:       w_state_d = tms_i ? SelectDrScan   : RunTestIdle;
            default:        w_state_d = TestLogicReset;
        endcase
    end

    // Instruction register: shift stage plus latched instruction.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            r_ir_shift <= '0;
            r_ir_q     <= IR_IDCODE;
        end else begin
            unique case (r_state)
                TestLogicReset: r_ir_q     <= IR_IDCODE;
                CaptureIr:      r_ir_shift <= IR_CAPTURE;
                ShiftIr:        r_ir_shift <= {td_i, r_ir_shift[IR_W-1:1]};
                UpdateIr:       r_ir_q     <= r_ir_shift;
                default:        ;
            endcase
        end
    end

    assign w_sel_idcode = (r_ir_q == IR_IDCODE);
    assign w_sel_dtmcs  = (r_ir_q == IR_DTMCS);
    assign w_sel_dmi    = (r_ir_q == IR_DMI);
    assign w_sel_bypass = !(w_sel_idcode || w_sel_dtmcs || w_sel_dmi);

    // Local data registers; only the selected one captures or shifts.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            r_idcode <= '0;
            r_bypass <= 1'b0;
        end else begin
            if (w_sel_idcode) begin
                if (r_state == CaptureDr) begin
                    r_idcode <= IdcodeValue;
                end else if (r_state == ShiftDr) begin
                    r_idcode <= {td_i, r_idcode[IDC_W-1:1]};
                end
            end
            if (w_sel_bypass) begin
                if (r_state == CaptureDr) begin
                    r_bypass <= 1'b0;
                end else if (r_state == ShiftDr) begin
                    r_bypass <= td_i;
                end
            end
        end
    end

    always_comb begin
        w_tdo = 1'b0;
        if (r_state == ShiftIr) begin
            w_tdo = r_ir_shift[0];
        end else if (r_state == ShiftDr) begin
            if (w_sel_idcode) begin
                w_tdo = r_idcode[0];
            end else if (w_sel_dtmcs) begin
                w_tdo = dtmcs_tdo_i;
            end else if (w_sel_dmi) begin
                w_tdo = dmi_tdo_i;
            end else begin
                w_tdo = r_bypass;
            end
        end
    end

    // TDO launches on the falling edge so the probe samples a stable bit on the rising edge.
    always_ff @(negedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            r_td     <= 1'b0;
            r_tdo_oe <= 1'b0;
        end else begin
            r_td     <= w_tdo;
            r_tdo_oe <= (r_state == ShiftIr) || (r_state == ShiftDr);
        end
    end

    assign td_o           = r_td;
    assign tdo_oe_o       = r_tdo_oe;
    assign dmi_clear_o    = (r_state == TestLogicReset);
    assign capture_o      = (r_state == CaptureDr);
    assign shift_o        = (r_state == ShiftDr);
    assign update_o       = (r_state == UpdateDr);
    assign dtmcs_select_o = w_sel_dtmcs;
    assign dmi_select_o   = w_sel_dmi;

endmodule
